// File: rtl/hgcal_fc_calib_pkg.sv
// Shared types and constants for the HGCAL fast-control calibration monitor.
package hgcal_fc_calib_pkg;

    localparam int BX_PER_ORBIT_DEF = 3564;
    localparam int BX_W             = 12;
    localparam int D_W              = 13;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_OVERLAP = 1;
    localparam int ERR_BXPHASE = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_L1A = 1'b1
    } fc_state_e;

    // A programmed delay of zero is treated as one BX.
    function automatic logic [D_W-1:0] eff_delay(input logic [BX_W-1:0] d);
        return (d == '0) ? D_W'(1) : D_W'(d);
    endfunction

endpackage

// File: rtl/hgcal_fc_bx_counter.sv
// Local BX counter: orbit-sync reload, wrap at end of orbit, and a phase
// error strobe when the orbit sync does not land on the last BX.
module hgcal_fc_bx_counter import hgcal_fc_calib_pkg::*; #(
    parameter int BX_PER_ORBIT = BX_PER_ORBIT_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_orbit_sync,
    output logic [BX_W-1:0] o_bx,
    output logic            o_phase_err
);

    localparam logic [BX_W-1:0] BX_LAST = BX_W'(BX_PER_ORBIT - 1);

    logic [BX_W-1:0] r_bx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_bx <= '0;
        else if (i_orbit_sync || (r_bx == BX_LAST))
            r_bx <= '0;
        else
            r_bx <= r_bx + BX_W'(1);
    end

    assign o_bx        = r_bx;
    assign o_phase_err = i_orbit_sync && (r_bx != BX_LAST);

endmodule

// File: rtl/hgcal_fc_calib_monitor.sv
// Pairs FC calibration requests with the L1A at the programmed delay and keeps
// calibration status counters. HGCAL_FC_CALIB_ERRLATCH_EN enables sticky err_flags.
module hgcal_fc_calib_monitor import hgcal_fc_calib_pkg::*; #(
    parameter int BX_PER_ORBIT = BX_PER_ORBIT_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk40,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_orbit_sync,
    input  logic             i_fc_calib_req,
    input  logic             i_fc_l1a,
    input  logic [BX_W-1:0]  i_expected_delay,
    input  logic [3:0]       i_tolerance,
    input  logic             i_clear_counters,
    output logic [BX_W-1:0]  o_bx_now,
    output logic [BX_W-1:0]  o_bx_calib_req,
    output logic [BX_W-1:0]  o_last_delay,
    output logic             o_calib_l1a,
    output logic             o_normal_l1a,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt_calib_ok,
    output logic [CNT_W-1:0] o_cnt_calib_err,
    output logic [2:0]       o_err_flags
);

    fc_state_e        r_state, w_state_nxt;
    logic [D_W-1:0]   r_dcnt, r_win_lo, r_win_hi;
    logic [D_W-1:0]   w_e, w_lo, w_hi, w_tol;
    logic [BX_W-1:0]  w_bx;
    logic [CNT_W-1:0] r_cnt_ok, r_cnt_err;
    logic             w_bx_phase, w_active, w_match, w_timeout, w_overlap, w_accept;

    hgcal_fc_bx_counter #(
        .BX_PER_ORBIT(BX_PER_ORBIT)
    ) u_bx_counter (
        .i_clk        (i_clk40),
        .i_rst_n      (i_reset_n),
        .i_orbit_sync (i_orbit_sync),
        .o_bx         (w_bx),
        .o_phase_err  (w_bx_phase)
    );

    // Window bounds are computed at request time and frozen for the sequence.
    assign w_e   = eff_delay(i_expected_delay);
    assign w_tol = D_W'(i_tolerance);
    assign w_hi  = w_e + w_tol;
    assign w_lo  = (w_e > w_tol) ? (w_e - w_tol) : D_W'(1);

    // r_dcnt holds the delay D of the current cycle while waiting (1 right after the request).
    assign w_active  = (r_state == WAIT_L1A) && i_enable;
    assign w_timeout = w_active && (r_dcnt == (r_win_hi + D_W'(1)));
    assign w_match   = w_active && i_fc_l1a && (r_dcnt >= r_win_lo) && (r_dcnt <= r_win_hi);
    assign w_overlap = w_active && i_fc_calib_req && !w_timeout;
    assign w_accept  = i_enable && i_fc_calib_req && ((r_state == IDLE) || w_timeout);

    always_ff @(posedge i_clk40 or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable)
            w_state_nxt = IDLE;
        else if (w_accept)
            w_state_nxt = WAIT_L1A;
        else if (w_match || w_timeout)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk40 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dcnt         <= '0;
            r_win_lo       <= '0;
            r_win_hi       <= '0;
            o_bx_calib_req <= '0;
            o_last_delay   <= '0;
            o_calib_l1a    <= 1'b0;
            o_normal_l1a   <= 1'b0;
        end else begin
            o_calib_l1a  <= w_match;
            o_normal_l1a <= i_fc_l1a && !w_match;
            if (w_match)
                o_last_delay <= r_dcnt[BX_W-1:0];
            if (w_accept) begin
                r_dcnt         <= D_W'(1);
                r_win_lo       <= w_lo;
                r_win_hi       <= w_hi;
                o_bx_calib_req <= w_bx;
            end else if (r_state == WAIT_L1A) begin
                r_dcnt <= r_dcnt + D_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk40 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (i_clear_counters) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else begin
            if (w_match && !(&r_cnt_ok))
                r_cnt_ok <= r_cnt_ok + CNT_W'(1);
            if ((w_timeout || w_overlap) && !(&r_cnt_err))
                r_cnt_err <= r_cnt_err + CNT_W'(1);
        end
    end

    assign o_bx_now        = w_bx;
    assign o_busy          = (r_state == WAIT_L1A);
    assign o_cnt_calib_ok  = r_cnt_ok;
    assign o_cnt_calib_err = r_cnt_err;

`ifdef HGCAL_FC_CALIB_ERRLATCH_EN
    logic [2:0] r_err_flags;

    always_ff @(posedge i_clk40 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err_flags <= '0;
        end else if (i_clear_counters) begin
            r_err_flags <= '0;
        end else begin
            r_err_flags[ERR_TIMEOUT] <= r_err_flags[ERR_TIMEOUT] | w_timeout;
            r_err_flags[ERR_OVERLAP] <= r_err_flags[ERR_OVERLAP] | w_overlap;
            r_err_flags[ERR_BXPHASE] <= r_err_flags[ERR_BXPHASE] | w_bx_phase;
        end
    end

    assign o_err_flags = r_err_flags;
`else
    logic w_unused_bx_phase;
    assign w_unused_bx_phase = w_bx_phase;
    assign o_err_flags       = 3'b000;
`endif

endmodule

// File: tb/tb_hgcal_fc_calib_monitor.sv
// Bench for hgcal_fc_calib_monitor: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based reference model.
module tb_hgcal_fc_calib_monitor;

    localparam int BXN  = 3564;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, en, os, rq, l1, clr;
    logic [11:0]   ed;
    logic [3:0]    tol;
    logic [11:0]   bx_now, bx_calib_req, last_delay;
    logic          calib_l1a, normal_l1a, busy;
    logic [CW-1:0] cnt_ok, cnt_err;
    logic [2:0]    err_flags;

    always #5 clk = ~clk;

    hgcal_fc_calib_monitor #(
        .BX_PER_ORBIT(BXN),
        .CNT_W(CW)
    ) dut (
        .i_clk40          (clk),
        .i_reset_n        (rst_n),
        .i_enable         (en),
        .i_orbit_sync     (os),
        .i_fc_calib_req   (rq),
        .i_fc_l1a         (l1),
        .i_expected_delay (ed),
        .i_tolerance      (tol),
        .i_clear_counters (clr),
        .o_bx_now         (bx_now),
        .o_bx_calib_req   (bx_calib_req),
        .o_last_delay     (last_delay),
        .o_calib_l1a      (calib_l1a),
        .o_normal_l1a     (normal_l1a),
        .o_busy           (busy),
        .o_cnt_calib_ok   (cnt_ok),
        .o_cnt_calib_err  (cnt_err),
        .o_err_flags      (err_flags)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Reference model state: pending request remembered by its cycle timestamp.
    int m_cyc = 0, m_bx = 0, m_treq = 0, m_lo = 0, m_hi = 0, m_ok = 0, m_err = 0;
    bit m_pend = 1'b0;
    int e_bxreq = 0, e_last = 0;
    bit e_cal = 1'b0, e_nor = 1'b0;
    bit [2:0] e_flags = 3'b000;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : model
        int d, e, t;
        bit ph, mt, to, ov, ac;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cyc = 0; m_bx = 0; m_treq = 0; m_lo = 0; m_hi = 0;
                m_ok = 0; m_err = 0; m_pend = 0;
                e_bxreq = 0; e_last = 0; e_cal = 0; e_nor = 0; e_flags = 3'b000;
            end else begin
                d = 0;
                ph = os && (m_bx != BXN - 1);
                mt = 0; to = 0; ov = 0;
                if (en && m_pend) begin
                    d  = m_cyc - m_treq;
                    mt = l1 && (d >= m_lo) && (d <= m_hi);
                    to = d > m_hi;
                    ov = rq && !to;
                end
                ac = en && rq && (!m_pend || to);
                if (!en || mt || to) m_pend = 0;
                if (ac) begin
                    e = (ed == 12'd0) ? 1 : int'(ed);
                    t = int'(tol);
                    m_pend  = 1;
                    m_treq  = m_cyc;
                    m_lo    = (e - t < 1) ? 1 : e - t;
                    m_hi    = e + t;
                    e_bxreq = m_bx;
                end
                e_cal = mt;
                e_nor = l1 && !mt;
                if (mt) e_last = d % 4096;
                if (clr) begin
                    m_ok = 0; m_err = 0; e_flags = 3'b000;
                end else begin
                    if (mt && m_ok < CMAX) m_ok++;
                    if ((to || ov) && m_err < CMAX) m_err++;
                    e_flags = e_flags | {ph, ov, to};
                end
                m_bx = os ? 0 : (m_bx + 1) % BXN;
                m_cyc++;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("bx_now", int'(bx_now), m_bx);
                chk("bx_calib_req", int'(bx_calib_req), e_bxreq);
                chk("last_delay", int'(last_delay), e_last);
                chk("calib_l1a", int'(calib_l1a), int'(e_cal));
                chk("normal_l1a", int'(normal_l1a), int'(e_nor));
                chk("busy", int'(busy), int'(m_pend));
                chk("cnt_calib_ok", int'(cnt_ok), m_ok);
                chk("cnt_calib_err", int'(cnt_err), m_err);
`ifdef HGCAL_FC_CALIB_ERRLATCH_EN
                chk("err_flags", int'(err_flags), int'(e_flags));
`else
                chk("err_flags", int'(err_flags), 0);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit p_rq, input bit p_l1, input bit p_os);
        rq = p_rq; l1 = p_l1; os = p_os;
        tick(1);
        rq = 1'b0; l1 = 1'b0; os = 1'b0;
    endtask

    task automatic wait_bx(input int v);
        int k;
        k = 0;
        while (m_bx != v && k < 5000) begin
            tick(1);
            k++;
        end
        if (m_bx != v) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_bx: bx %0d not reached, at %0d", v, m_bx);
        end
    endtask

    task automatic lit_flags(input string nm, input int exp);
`ifdef HGCAL_FC_CALIB_ERRLATCH_EN
        chk(nm, int'(err_flags), exp);
`else
        chk(nm, int'(err_flags), 0 * exp);
`endif
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; os = 1'b1; rq = 1'b0; l1 = 1'b0; clr = 1'b0;
        ed = '0; tol = '0;
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        tick(2);
        chk("rst_bx_now", int'(bx_now), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt_ok", int'(cnt_ok), 0);
        lit_flags("rst_err_flags", 0);
        os = 1'b0;
        #2 rst_n = 1'b1;
        tick(1);

        // Orbit syncs aligned to the last BX, then a free-running wrap.
        for (int i = 0; i < 2; i++) begin
            wait_bx(BXN - 1);
            pulse(0, 0, 1);
            chk("orbit_sync_wrap", int'(bx_now), 0);
        end
        wait_bx(BXN - 1);
        tick(1);
        chk("natural_wrap", int'(bx_now), 0);
        lit_flags("orbit_no_phase", 0);

        // Exact match.
        en = 1'b1; ed = 12'd20; tol = 4'd0;
        wait_bx(50);
        pulse(1, 0, 0);
        tick(19);
        pulse(0, 1, 0);
        chk("match_calib", int'(calib_l1a), 1);
        chk("match_last", int'(last_delay), 20);
        chk("match_ok", int'(cnt_ok), 1);
        chk("match_bxreq", int'(bx_calib_req), 50);
        chk("match_bxnow", int'(bx_now), 71);
        chk("match_busy", int'(busy), 0);

        // Early L1A inside a tolerance window, then the upper edge.
        ed = 12'd20; tol = 4'd2;
        pulse(1, 0, 0);
        tick(16);
        pulse(0, 1, 0);
        chk("early_normal", int'(normal_l1a), 1);
        chk("early_busy", int'(busy), 1);
        tick(4);
        pulse(0, 1, 0);
        chk("win_hi_calib", int'(calib_l1a), 1);
        chk("win_hi_last", int'(last_delay), 22);
        chk("win_hi_ok", int'(cnt_ok), 2);

        // Timeout at D = E + tol + 1.
        ed = 12'd10; tol = 4'd1;
        pulse(1, 0, 0);
        tick(11);
        chk("tmo_busy_before", int'(busy), 1);
        tick(1);
        chk("tmo_busy_after", int'(busy), 0);
        chk("tmo_err", int'(cnt_err), 1);
        lit_flags("tmo_flags", 1);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_ok", int'(cnt_ok), 0);
        chk("clr_err", int'(cnt_err), 0);
        lit_flags("clr_flags", 0);

        // Overlapping request is ignored but counted.
        ed = 12'd30; tol = 4'd0;
        pulse(1, 0, 0);
        tick(4);
        pulse(1, 0, 0);
        chk("ovl_err", int'(cnt_err), 1);
        chk("ovl_busy", int'(busy), 1);
        tick(24);
        pulse(0, 1, 0);
        chk("ovl_calib", int'(calib_l1a), 1);
        chk("ovl_ok", int'(cnt_ok), 1);
        lit_flags("ovl_flags", 2);

        // Zero programmed delay behaves as one BX; same-cycle req+L1A.
        ed = 12'd0; tol = 4'd0;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("e0_calib", int'(calib_l1a), 1);
        chk("e0_last", int'(last_delay), 1);
        pulse(1, 1, 0);
        chk("same_normal", int'(normal_l1a), 1);
        chk("same_busy", int'(busy), 1);
        pulse(0, 1, 0);
        chk("same_calib", int'(calib_l1a), 1);

        // Misaligned orbit sync.
        wait_bx(100);
        pulse(0, 0, 1);
        chk("phase_bx", int'(bx_now), 0);
        lit_flags("phase_flags", 6);

        // Enable drop while waiting: back to idle, nothing counted.
        ed = 12'd50; tol = 4'd3;
        pulse(1, 0, 0);
        tick(3);
        en = 1'b0;
        tick(1);
        chk("endrop_busy", int'(busy), 0);
        chk("endrop_err", int'(cnt_err), 1);
        chk("endrop_ok", int'(cnt_ok), 3);
        en = 1'b1;

        // Asynchronous reset in the middle of a sequence.
        ed = 12'd40;
        pulse(1, 0, 0);
        tick(5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_bx", int'(bx_now), 0);
        chk("arst_ok", int'(cnt_ok), 0);
        chk("arst_err", int'(cnt_err), 0);
        chk("arst_bxreq", int'(bx_calib_req), 0);
        chk("arst_last", int'(last_delay), 0);
        lit_flags("arst_flags", 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Saturation of both counters.
        ed = 12'd4095; tol = 4'd15;
        pulse(1, 0, 0);
        rq = 1'b1;
        tick(300);
        rq = 1'b0;
        chk("sat_err", int'(cnt_err), CMAX);
        en = 1'b0; tick(1); en = 1'b1;
        ed = 12'd0; tol = 4'd0;
        for (int i = 0; i < 300; i++) begin
            pulse(1, 0, 0);
            pulse(0, 1, 0);
        end
        chk("sat_ok", int'(cnt_ok), CMAX);
        chk("sat_err_hold", int'(cnt_err), CMAX);
        clr = 1'b1; tick(1); clr = 1'b0;

        // Random traffic.
        for (int i = 0; i < 20000; i++) begin
            en  = ($urandom_range(99) < 97);
            rq  = ($urandom_range(99) < 4);
            l1  = ($urandom_range(99) < 8);
            os  = ($urandom_range(199) == 0);
            clr = ($urandom_range(299) == 0);
            ed  = ($urandom_range(9) == 0) ? 12'd0 : 12'($urandom_range(40));
            tol = 4'($urandom_range(15));
            tick(1);
        end
        rq = 1'b0; l1 = 1'b0; os = 1'b0; clr = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
